// File: rtl/reg_scoreboard.sv
// Register writeback scoreboard between ID and EX: per-register pending-write counters
// stall ID while an operand still has an outstanding write; EX writebacks release them.
module reg_scoreboard #(
  parameter int NREG   = 16,
  parameter int NAME_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_v_i,
  input  logic                    issue_wb_i,
  input  logic [NAME_W-1:0]       rs_name_i,
  input  logic [NAME_W-1:0]       rd_name_i,
  input  logic                    wb_v_i,
  input  logic [NAME_W-1:0]       wb_name_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    issue_ack_o,
  output logic                    rs_busy_o,
  output logic                    rd_busy_o,
  output logic [NREG-1:0]         busy_vec_o,
  output logic [NAME_W+CNT_W-1:0] pending_o,
  output logic                    err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NAME_W+CNT_W-1:0]    pending;
  logic                       err;
  logic                       rd_sat, inc, wb_hit, dec, wb_err;

  assign rs_busy_o   = (cnt[rs_name_i] != '0);
  assign rd_busy_o   = (cnt[rd_name_i] != '0);
  assign rd_sat      = (cnt[rd_name_i] == CNT_MAX);
  assign stall_o     = issue_v_i & (rs_busy_o | rd_busy_o | (issue_wb_i & rd_sat));
  assign issue_ack_o = issue_v_i & ~stall_o;

  // A flush cycle discards both the issue and the writeback, including error detection.
  assign inc    = issue_ack_o & issue_wb_i & ~flush_i;
  assign wb_hit = wb_v_i & ~flush_i;
  assign dec    = wb_hit & (cnt[wb_name_i] != '0);
  assign wb_err = wb_hit & (cnt[wb_name_i] == '0);

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_busy
      assign busy_vec_o[g] = (cnt[g] != '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      err <= err | wb_err;
      if (flush_i) begin
        cnt     <= '0;
        pending <= '0;
      end else begin
        // Same-register inc and dec net to zero through the add/subtract below.
        for (int i = 0; i < NREG; i++) begin
          cnt[i] <= cnt[i]
                    + CNT_W'(inc && (rd_name_i == NAME_W'(i)))
                    - CNT_W'(dec && (wb_name_i == NAME_W'(i)));
        end
        pending <= pending + (NAME_W+CNT_W)'(inc) - (NAME_W+CNT_W)'(dec);
      end
    end
  end

  assign pending_o = pending;
  assign err_o     = err;

endmodule
